tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Four-channel time-division demultiplexer: the receive end of a 4:1 slot-interleaved stream.
- A mux selecting a, b, c, d in turn drives one serial lane; this block separates that lane back into four channel words.
- It acquires frame alignment from a slot-0 sync marker and presents all four channels together once per frame.
- It flags alignment errors and resynchronises without a reset.

Parameters:
DATA_W, 1, width of each slot word and each channel output.
SYNC_EVERY_FRAME, 1, 1 = frame_sync is required on every slot-0 beat; 0 = after lock, slots free-run and frame_sync is only checked when present.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  din/frame_sync are valid this cycle (one beat = one slot).
frame_sync  input  1  marks the current beat as slot 0; ignored when in_valid=0.
din  input  DATA_W  slot data.
out_a  output  DATA_W  channel 0 (slot 0) word of the last complete frame.
out_b  output  DATA_W  channel 1 (slot 1) word.
out_c  output  DATA_W  channel 2 (slot 2) word.
out_d  output  DATA_W  channel 3 (slot 3) word.
frame_valid  output  1  one-cycle pulse: out_a..out_d just updated.
locked  output  1  high while in LOCKED state.
sync_err  output  1  one-cycle pulse on a detected alignment error.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_a..out_d=0; frame_valid, sync_err, locked=0.
  - Slot counter=0, shadow regs=0, state=HUNT.
  - Reset mid-frame discards the partial frame; outputs do not update.
- Only beats with in_valid=1 are acted on. An in_valid=0 cycle holds all state; frame_valid and sync_err are 0 that cycle.
- Storage:
  - 2-bit slot counter; shadow regs sh0..sh2 (DATA_W each).
  - Output regs are double-buffered: they change only on frame completion.
- HUNT:
  - Beats with frame_sync=0 are discarded.
  - A beat with frame_sync=1: sh0<=din, slot<=1, state<=LOCKED.
  - locked is registered and reads 1 from the next cycle.
- LOCKED, per valid beat:
  - slot!=0 and frame_sync=1 (early sync):
    - sync_err=1 next cycle; partial frame dropped; no frame_valid.
    - Beat is treated as a new slot 0: sh0<=din, slot<=1. Stay LOCKED.
  - slot==0 and frame_sync=0:
    - SYNC_EVERY_FRAME=1: sync_err=1 next cycle, beat discarded, state<=HUNT, locked<=0.
    - SYNC_EVERY_FRAME=0: accepted as slot 0.
  - Otherwise: sh[slot]<=din, slot<=slot+1.
  - slot==3 accepted:
    - out_a<=sh0, out_b<=sh1, out_c<=sh2, out_d<=din, all in the same edge.
    - frame_valid=1 in the cycle after the edge (registered, 1-cycle pulse). slot wraps to 0.
- Latency: the slot-3 beat is sampled at edge N; outputs and frame_valid are visible after edge N.
- Back-to-back frames with no idle cycles: frame_valid pulses every 4th cycle; outputs hold between frames.
- sync_err and frame_valid are never both 1 in the same cycle.

Test Plan:
- Reset, then 4 valid beats din=1,0,1,1 (DATA_W=1) with frame_sync on beat 1 -> one cycle after the 4th beat: frame_valid=1, out_a..d=1,0,1,1, locked=1.
- DATA_W=8, two back-to-back frames 0x11,0x22,0x33,0x44 then 0xA1,0xB2,0xC3,0xD4 (sync on beats 1 and 5) -> frame_valid pulses 4 cycles apart; outputs update to the second set only after beat 8.
- Insert in_valid=0 gaps of 1-3 cycles between slots of a frame -> same output values; frame_valid is delayed by the gap total; no sync_err.
- Early sync: beats 0x11(sync),0x22,0x55(sync),0x66,0x77,0x88 -> sync_err pulse after beat 3; no frame_valid for the aborted frame; then frame_valid with out=0x55,0x66,0x77,0x88.
- SYNC_EVERY_FRAME=1, second frame missing sync at slot 0 -> sync_err, locked=0, no further frame_valid until the next frame_sync. Repeat with SYNC_EVERY_FRAME=0 -> no error, frame accepted.
- Assert rst_n=0 after 2 beats of a frame, release, then send a full frame -> outputs stay 0 until that full frame completes; HUNT ignores pre-sync beats.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: aligns to a slot-0 sync marker and
// presents all four channel words together once per complete frame.
module tdm_demux4 #(
    parameter int unsigned DATA_W           = 1,
    parameter bit          SYNC_EVERY_FRAME = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              frame_sync,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam logic StHunt   = 1'b0;
    localparam logic StLocked = 1'b1;

    logic              state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [DATA_W-1:0] sh0_q, sh0_d;
    logic [DATA_W-1:0] sh1_q, sh1_d;
    logic [DATA_W-1:0] sh2_q, sh2_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [DATA_W-1:0] out_c_q, out_c_d;
    logic [DATA_W-1:0] out_d_q, out_d_d;
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_c_d       = out_c_q;
        out_d_d       = out_d_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (in_valid) begin
            if (state_q == StHunt) begin
                if (frame_sync) begin
                    sh0_d   = din;
                    slot_d  = 2'd1;
                    state_d = StLocked;
                end
            end else if (frame_sync && (slot_q != 2'd0)) begin
                // Early sync: drop the partial frame and restart on this beat.
                sync_err_d = 1'b1;
                sh0_d      = din;
                slot_d     = 2'd1;
            end else if (!frame_sync && (slot_q == 2'd0) && SYNC_EVERY_FRAME) begin
                sync_err_d = 1'b1;
                state_d    = StHunt;
            end else begin
                unique case (slot_q)
                    2'd0: sh0_d = din;
                    2'd1: sh1_d = din;
                    2'd2: sh2_d = din;
                    2'd3: begin
                        out_a_d       = sh0_q;
                        out_b_d       = sh1_q;
                        out_c_d       = sh2_q;
                        out_d_d       = din;
                        frame_valid_d = 1'b1;
                    end
                    default: ;
                endcase
                slot_d = slot_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StHunt;
            slot_q        <= 2'd0;
            sh0_q         <= '0;
            sh1_q         <= '0;
            sh2_q         <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_c_q       <= '0;
            out_d_q       <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            sh2_q         <= sh2_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_c_q       <= out_c_d;
            out_d_q       <= out_d_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_c       = out_c_q;
    assign out_d       = out_d_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == StLocked);

endmodule
